// File: rtl/simple_uart.sv
// simple_uart: full-duplex 8N1 UART with run-time clocks-per-bit divisor; define SIMPLE_UART_FRAME_CHECK_EN to drop frames with a low stop bit
module simple_uart (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] clkdiv,
  output logic        tx,
  input  logic [7:0]  txin,
  input  logic        txrdy,
  output logic        txactive,
  input  logic        rx,
  output logic [7:0]  rxout,
  output logic        rxrdy,
  output logic        rxactive
);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t tx_state, tx_state_n, rx_state, rx_state_n;
  logic [15:0] div_eff, tx_div, tx_cnt, rx_div, rx_cnt;
  logic [7:0] tx_sh, rx_sh;
  logic [2:0] tx_idx, rx_idx;
  logic tx_end, rx_s1, rx_s2, rx_s3, rx_fall, rx_samp, rx_ok;
  assign div_eff = clkdiv < 16'd2 ? 16'd2 : clkdiv;
  assign tx_end = tx_cnt == tx_div - 16'd1;
  assign txactive = tx_state != IDLE;
  always_comb begin
    tx_state_n = tx_state;
    case (tx_state)
      IDLE:    if (txrdy) tx_state_n = START;
      START:   if (tx_end) tx_state_n = DATA;
      DATA:    if (tx_end && tx_idx == 3'd7) tx_state_n = STOP;
      STOP:    if (tx_end) tx_state_n = IDLE;
      default: tx_state_n = IDLE;
    endcase
  end
  // the shift register fills with ones, so the ninth shift-out is the stop bit
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state <= IDLE;
      tx <= 1'b1;
      tx_cnt <= 16'd0;
      tx_div <= 16'd2;
      tx_sh <= 8'd0;
      tx_idx <= 3'd0;
    end else begin
      tx_state <= tx_state_n;
      tx_cnt <= (tx_state == IDLE || tx_end) ? 16'd0 : tx_cnt + 16'd1;
      if (tx_state == IDLE && txrdy) begin
        tx_sh <= txin;
        tx_div <= div_eff;
        tx <= 1'b0;
        tx_idx <= 3'd0;
      end else if (tx_end && (tx_state == START || tx_state == DATA)) begin
        tx <= tx_sh[0];
        tx_sh <= {1'b1, tx_sh[7:1]};
        if (tx_state == DATA) tx_idx <= tx_idx + 3'd1;
      end
    end
  end
  // START samples at half a bit; every later sample is one full bit after the previous
  assign rx_fall = rx_s3 & ~rx_s2;
  assign rx_samp = rx_cnt == (rx_state == START ? {1'b0, rx_div[15:1]} - 16'd1 : rx_div - 16'd1);
  assign rxactive = rx_state != IDLE;
`ifdef SIMPLE_UART_FRAME_CHECK_EN
  assign rx_ok = rx_s2;
`else
  assign rx_ok = 1'b1;
`endif
  always_comb begin
    rx_state_n = rx_state;
    case (rx_state)
      IDLE:    if (rx_fall) rx_state_n = START;
      START:   if (rx_samp) rx_state_n = rx_s2 ? IDLE : DATA;
      DATA:    if (rx_samp && rx_idx == 3'd7) rx_state_n = STOP;
      STOP:    if (rx_samp) rx_state_n = IDLE;
      default: rx_state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      {rx_s3, rx_s2, rx_s1} <= 3'b111;
      rx_state <= IDLE;
      rx_cnt <= 16'd0;
      rx_div <= 16'd2;
      rx_sh <= 8'd0;
      rx_idx <= 3'd0;
      rxout <= 8'd0;
      rxrdy <= 1'b0;
    end else begin
      {rx_s3, rx_s2, rx_s1} <= {rx_s2, rx_s1, rx};
      rx_state <= rx_state_n;
      rx_cnt <= (rx_state == IDLE || rx_samp) ? 16'd0 : rx_cnt + 16'd1;
      rxrdy <= rx_state == STOP && rx_samp && rx_ok;
      if (rx_state == IDLE && rx_fall) begin
        rx_div <= div_eff;
        rx_idx <= 3'd0;
      end
      if (rx_state == DATA && rx_samp) begin
        rx_sh <= {rx_s2, rx_sh[7:1]};
        rx_idx <= rx_idx + 3'd1;
      end
      if (rx_state == STOP && rx_samp && rx_ok) rxout <= rx_sh;
    end
  end
endmodule

// File: tb/tb_simple_uart.sv
// tb_simple_uart: directed bench for simple_uart with a frame-level TX/RX model checked every cycle
module tb_simple_uart;
  logic clk = 1'b0, rst = 1'b1, txrdy = 1'b0, rx_drv = 1'b1, loop = 1'b0;
  logic [15:0] clkdiv = 16'd48;
  logic [7:0] txin = 8'd0;
  logic tx, txactive, rxrdy, rxactive, rx_line;
  logic [7:0] rxout;
  int vecs = 0, errs = 0, cyc = 0;
  // model state: one TX frame and one expected RX frame at a time
  int t_s = 0, t_d = 2, r_s = 0, r_d = 2, r_kind = 0, pulses = 0, rel, ws;
  logic t_have = 1'b0, r_have = 1'b0, pe;
  logic [7:0] t_b = 8'd0, r_byte = 8'd0, m_rxout = 8'd0;
  logic [9:0] bits41 = 10'b1010000010;

  assign rx_line = loop ? tx : rx_drv;

  simple_uart dut (
    .clk(clk), .rst(rst), .clkdiv(clkdiv), .tx(tx), .txin(txin), .txrdy(txrdy),
    .txactive(txactive), .rx(rx_line), .rxout(rxout), .rxrdy(rxrdy), .rxactive(rxactive)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    vecs++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", nm, cyc, a, e);
    end
  endtask

  function automatic int eff(input logic [15:0] v);
    return v < 16'd2 ? 2 : int'(v);
  endfunction

  function automatic logic tx_act(input int c);
    return t_have && c >= t_s && c < t_s + 10 * t_d;
  endfunction

  function automatic logic tx_exp(input int c);
    int k;
    if (!tx_act(c)) return 1'b1;
    k = (c - t_s) / t_d;
    return k == 0 ? 1'b0 : k <= 8 ? t_b[k-1] : 1'b1;
  endfunction

  function automatic logic pulse_exp(input int kind);
`ifdef SIMPLE_UART_FRAME_CHECK_EN
    return kind == 0;
`else
    return kind != 1;
`endif
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      t_have = 1'b0;
      m_rxout = 8'd0;
    end else if (!tx_act(cyc) && txrdy) begin
      t_have = 1'b1;
      t_s = cyc + 1;
      t_d = eff(clkdiv);
      t_b = txin;
    end
    cyc = cyc + 1;
  end

  always @(negedge clk) if (cyc > 0) begin
    chk("tx", 32'(tx), 32'(tx_exp(cyc)));
    chk("txactive", 32'(txactive), 32'(tx_act(cyc)));
    if (!r_have) begin
      chk("rxactive_idle", 32'(rxactive), 0);
      chk("rxrdy_idle", 32'(rxrdy), 0);
      chk("rxout_idle", 32'(rxout), 32'(m_rxout));
    end else if (r_kind == 1) begin
      rel = cyc - r_s;
      if (rel >= 4 && rel <= r_d / 2 - 4) chk("rxactive_false_start", 32'(rxactive), 1);
      if (rel >= r_d / 2 + 4) chk("rxactive_false_drop", 32'(rxactive), 0);
      chk("rxrdy_false", 32'(rxrdy), 0);
      chk("rxout_false", 32'(rxout), 32'(m_rxout));
      if (rel >= r_d / 2 + 6) r_have = 1'b0;
    end else begin
      rel = cyc - r_s;
      ws = 9 * r_d + r_d / 2;
      pe = pulse_exp(r_kind);
      if (rel >= 4 && rel < ws) chk("rxactive_frame", 32'(rxactive), 1);
      if (rel >= ws && rel <= ws + 4) begin
        if (!pe) begin
          chk("rxrdy_dropped", 32'(rxrdy), 0);
          chk("rxout_dropped", 32'(rxout), 32'(m_rxout));
        end else if (rxrdy) begin
          pulses++;
          chk("rxout_at_rxrdy", 32'(rxout), 32'(r_byte));
        end
      end else begin
        chk("rxrdy_outside", 32'(rxrdy), 0);
        if (rel < ws) chk("rxout_hold", 32'(rxout), 32'(m_rxout));
      end
      if (rel == ws + 5) begin
        chk("rxrdy_count", pulses, pe ? 1 : 0);
        if (pe) m_rxout = r_byte;
        r_have = 1'b0;
        chk("rxactive_end", 32'(rxactive), 0);
        chk("rxout_end", 32'(rxout), 32'(m_rxout));
      end
    end
  end

  task automatic send_tx(input logic [7:0] b);
    @(posedge clk); #1;
    txin = b;
    txrdy = 1'b1;
    @(posedge clk); #1;
    txrdy = 1'b0;
  endtask

  task automatic rx_frame(input logic [7:0] b, input logic sb, input int kind);
    @(posedge clk); #1;
    r_s = cyc; r_d = eff(clkdiv); r_byte = b; r_kind = kind; pulses = 0; r_have = 1'b1;
    rx_drv = 1'b0;
    for (int k = 0; k < 9; k++) begin
      repeat (r_d) @(posedge clk);
      #1 rx_drv = k < 8 ? b[k] : sb;
    end
    repeat (r_d) @(posedge clk);
    #1 rx_drv = 1'b1;
    repeat (30) @(posedge clk);
  endtask

  task automatic rx_false_start();
    @(posedge clk); #1;
    r_s = cyc; r_d = eff(clkdiv); r_kind = 1; pulses = 0; r_have = 1'b1;
    rx_drv = 1'b0;
    repeat (10) @(posedge clk);
    #1 rx_drv = 1'b1;
    repeat (60) @(posedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int cnt, gap;
    logic found;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_tx", 32'(tx), 1);
    chk("reset_rxout", 32'(rxout), 0);
    #1 rst = 1'b0;
    repeat (4) @(posedge clk);
    // 0x41 at 48 cycles/bit, with an ignored load strobe mid-frame
    send_tx(8'h41);
    cnt = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (txactive) cnt++;
      if (i % 48 == 24 && i / 48 < 10) chk("tx41_bit", 32'(tx), 32'(bits41[i/48]));
      if (i == 200) begin txin = 8'hFF; txrdy = 1'b1; end
      if (i == 201) txrdy = 1'b0;
    end
    chk("tx41_len", cnt, 480);
    // back-to-back with txrdy held high across the first frame
    clkdiv = 16'd16;
    @(posedge clk); #1;
    txin = 8'h33; txrdy = 1'b1;
    @(posedge clk); #1;
    txin = 8'h37;
    found = 1'b0;
    gap = 0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge clk);
      if (!txactive) begin
        found = 1'b1;
        while (!txactive && gap < 5) begin gap++; @(negedge clk); end
        txrdy = 1'b0;
      end
    end
    chk("b2b_found", 32'(found), 1);
    chk("b2b_gap", gap, 1);
    chk("b2b_start_bit", 32'(tx), 0);
    txrdy = 1'b0;
    repeat (220) @(posedge clk);
    // divisor below 2 and divisor change mid-frame
    clkdiv = 16'd1;
    send_tx(8'h3C);
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (i == 5) clkdiv = 16'd7;
      if (txactive) cnt++;
    end
    chk("tx_div1_len", cnt, 20);
    clkdiv = 16'd48;
    repeat (5) @(posedge clk);
    rx_frame(8'hA5, 1'b1, 0);
    chk("rx_a5", 32'(rxout), 32'h A5);
    rx_false_start();
    chk("rx_false_keep", 32'(rxout), 32'h A5);
    rx_frame(8'h5A, 1'b0, 2);
`ifdef SIMPLE_UART_FRAME_CHECK_EN
    chk("rx_framing", 32'(rxout), 32'h A5);
`else
    chk("rx_framing", 32'(rxout), 32'h 5A);
`endif
    // loopback: rx follows tx while both sides run
    clkdiv = 16'd16;
    @(posedge clk); #1;
    loop = 1'b1; txin = 8'h5C; txrdy = 1'b1;
    r_s = cyc + 1; r_d = 16; r_byte = 8'h5C; r_kind = 0; pulses = 0; r_have = 1'b1;
    @(posedge clk); #1;
    txrdy = 1'b0;
    repeat (180) @(posedge clk);
    #1 loop = 1'b0;
    chk("rx_loopback", 32'(rxout), 32'h 5C);
    // reset three bits into a frame, then a full frame
    send_tx(8'hC3);
    repeat (48) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_tx", 32'(tx), 1);
    chk("rst_mid_txactive", 32'(txactive), 0);
    chk("rst_mid_rxout", 32'(rxout), 0);
    send_tx(8'h96);
    cnt = 0;
    for (int i = 0; i < 170; i++) begin
      @(negedge clk);
      if (txactive) cnt++;
    end
    chk("tx_after_rst_len", cnt, 160);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
